fft8_seq_ctrl: RTL and testbench

Sequencing controller for an 8-point radix-2 DIT FFT that time-shares a single butterfly unit instead of instantiating twelve. It accepts 8 complex samples over a valid/ready stream and stores them in bit-reversed order in an in-place 8-entry register file. It then schedules 3 stages × 4 butterflies, one per cycle, with the correct operand addresses and twiddle indices, and streams the 8 bins out in natural order.

---
 rtl/fft8_pkg.sv | 50 +++++
 rtl/fft8_seq_ctrl_if.sv | 29 ++
 rtl/fft8_bfly_cplx.sv | 47 ++++
 rtl/fft8_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_fft8_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft8_pkg.sv
// Shared widths, FSM state type, twiddle ROM and bit-reverse helper for the
// time-shared 8-point radix-2 DIT FFT.
package fft8_pkg;

   localparam int DW = 9;
   localparam int TW = 10;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      UNLOAD  = 2'd2
   } state_e;

   // W[k] = exp(-j*2*pi*k/8) in Q1.8
   localparam logic signed [TW-1:0] W0_RE =  10'sd256;
   localparam logic signed [TW-1:0] W0_IM =  10'sd0;
   localparam logic signed [TW-1:0] W1_RE =  10'sd181;
   localparam logic signed [TW-1:0] W1_IM = -10'sd181;
   localparam logic signed [TW-1:0] W2_RE =  10'sd0;
   localparam logic signed [TW-1:0] W2_IM = -10'sd256;
   localparam logic signed [TW-1:0] W3_RE = -10'sd181;
   localparam logic signed [TW-1:0] W3_IM = -10'sd181;

   function automatic logic signed [TW-1:0] twid_re(input logic [1:0] k);
      logic signed [TW-1:0] w;
      case (k)
         2'd0:    w = W0_RE;
         2'd1:    w = W1_RE;
         2'd2:    w = W2_RE;
         default: w = W3_RE;
      endcase
      return w;
   endfunction

   function automatic logic signed [TW-1:0] twid_im(input logic [1:0] k);
      logic signed [TW-1:0] w;
      case (k)
         2'd0:    w = W0_IM;
         2'd1:    w = W1_IM;
         2'd2:    w = W2_IM;
         default: w = W3_IM;
      endcase
      return w;
   endfunction

   function automatic logic [2:0] bitrev3(input logic [2:0] c);
      return {c[0], c[1], c[2]};
   endfunction

endpackage

// File: rtl/fft8_seq_ctrl_if.sv
// Sample-in / bin-out stream bundle of the FFT sequencer plus its status flags.
interface fft8_seq_ctrl_if;
   import fft8_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_re;
   logic signed [DW-1:0] in_im;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_re;
   logic signed [DW-1:0] out_im;
   logic [2:0]           out_idx;
   logic                 busy;
   logic                 done;

   // slave: the FFT controller's view
   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, busy, done
   );

   // master: the producer/consumer driving the controller
   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, busy, done
   );

endinterface

// File: rtl/fft8_bfly_cplx.sv
// Combinational radix-2 butterfly: P = W*B, returns A+P and A-P, wrapping to DW.
module fft8_bfly_cplx
   import fft8_pkg::*;
#(
   parameter int DW_P = DW,
   parameter int TW_P = TW
) (
   input  logic signed [DW_P-1:0] a_re_i,
   input  logic signed [DW_P-1:0] a_im_i,
   input  logic signed [DW_P-1:0] b_re_i,
   input  logic signed [DW_P-1:0] b_im_i,
   input  logic signed [TW_P-1:0] w_re_i,
   input  logic signed [TW_P-1:0] w_im_i,
   output logic signed [DW_P-1:0] sum_re_o,
   output logic signed [DW_P-1:0] sum_im_o,
   output logic signed [DW_P-1:0] dif_re_o,
   output logic signed [DW_P-1:0] dif_im_o
);

   // one extra bit so the sum of two full products never overflows
   localparam int PW   = DW_P + TW_P + 1;
   localparam int FRAC = TW_P - 2;

   logic signed [PW-1:0]   br_x, bi_x, wr_x, wi_x;
   logic signed [PW-1:0]   pr_full, pi_full;
   logic signed [DW_P-1:0] p_re, p_im;

   always_comb begin
      br_x = PW'(b_re_i);
      bi_x = PW'(b_im_i);
      wr_x = PW'(w_re_i);
      wi_x = PW'(w_im_i);

      pr_full = wr_x * br_x - wi_x * bi_x;
      pi_full = wr_x * bi_x + wi_x * br_x;

      // arithmetic shift floors toward -inf; keep only the low DW bits
      p_re = DW_P'(pr_full >>> FRAC);
      p_im = DW_P'(pi_full >>> FRAC);

      sum_re_o = a_re_i + p_re;
      sum_im_o = a_im_i + p_im;
      dif_re_o = a_re_i - p_re;
      dif_im_o = a_im_i - p_im;
   end

endmodule

// File: rtl/fft8_seq_ctrl.sv
// 8-point DIT FFT sequencer: loads bit-reversed, runs 3x4 butterflies on one
// shared butterfly unit in place, then streams bins out in natural order.
module fft8_seq_ctrl
   import fft8_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   fft8_seq_ctrl_if.slave io
);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] s_q, s_d;
   logic [1:0] b_q, b_d;

   // in-place register file: combinational read, registered write, no reset
   logic signed [DW-1:0] mem_re_q [8];
   logic signed [DW-1:0] mem_im_q [8];

   logic                 load_we, bfly_we;
   logic [2:0]           span, top, bot, b_x;
   logic [1:0]           tw_k;
   logic signed [TW-1:0] w_re, w_im;
   logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;

   // butterfly addressing for stage s, butterfly b
   always_comb begin
      b_x  = {1'b0, b_q};
      span = 3'd1 << s_q;
      top  = ((b_x >> s_q) << (s_q + 2'd1)) | (b_x & (span - 3'd1));
      bot  = top + span;
      tw_k = (b_q & 2'(span - 3'd1)) << (2'd2 - s_q);
      w_re = twid_re(tw_k);
      w_im = twid_im(tw_k);
   end

   fft8_bfly_cplx #(
      .DW_P (DW),
      .TW_P (TW)
   ) u_bfly (
      .a_re_i   (mem_re_q[top]),
      .a_im_i   (mem_im_q[top]),
      .b_re_i   (mem_re_q[bot]),
      .b_im_i   (mem_im_q[bot]),
      .w_re_i   (w_re),
      .w_im_i   (w_im),
      .sum_re_o (sum_re),
      .sum_im_o (sum_im),
      .dif_re_o (dif_re),
      .dif_im_o (dif_im)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         s_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      s_d          = s_q;
      b_d          = b_q;
      load_we      = 1'b0;
      bfly_we      = 1'b0;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      io.out_re    = '0;
      io.out_im    = '0;
      io.out_idx   = '0;
      io.busy      = 1'b0;
      io.done      = 1'b0;

      unique case (state_q)
         LOAD: begin
            io.in_ready = 1'b1;
            if (io.in_valid) begin
               load_we = 1'b1;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  cnt_d   = '0;
                  state_d = COMPUTE;
               end
            end
         end

         COMPUTE: begin
            io.busy = 1'b1;
            bfly_we = 1'b1;
            b_d     = b_q + 2'd1;
            if (b_q == 2'd3) begin
               s_d = s_q + 2'd1;
               if (s_q == 2'd2) begin
                  s_d     = '0;
                  cnt_d   = '0;
                  state_d = UNLOAD;
               end
            end
         end

         UNLOAD: begin
            io.out_valid = 1'b1;
            io.out_re    = mem_re_q[cnt_q];
            io.out_im    = mem_im_q[cnt_q];
            io.out_idx   = cnt_q;
            if (io.out_ready) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  io.done = 1'b1;
                  state_d = LOAD;
               end
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // top and bot always differ, so both butterfly writes land in one edge
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem_re_q[bitrev3(cnt_q)] <= io.in_re;
         mem_im_q[bitrev3(cnt_q)] <= io.in_im;
      end
      if (bfly_we) begin
         mem_re_q[top] <= sum_re;
         mem_im_q[top] <= sum_im;
         mem_re_q[bot] <= dif_re;
         mem_im_q[bot] <= dif_im;
      end
   end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Self-checking bench for fft8_seq_ctrl: directed test-plan frames plus random
// frames checked against an integer DIT FFT model.
module tb_fft8_seq_ctrl;
   import fft8_pkg::*;

   logic clk = 1'b0;
   logic rst;

   fft8_seq_ctrl_if bus();

   fft8_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int fr[8], fi[8], er[8], ei[8];
   int W_RE[4] = '{256, 181, 0, -181};
   int W_IM[4] = '{0, -181, -256, -181};

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap9(input int v);
      logic [8:0] t;
      t = v[8:0];
      return int'($signed(t));
   endfunction

   // textbook in-place DIT: bit-reverse, then butterflies of half-size h
   task automatic model();
      int ar[8], ai[8];
      for (int n = 0; n < 8; n++) begin
         int r;
         r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
         ar[r] = fr[n];
         ai[r] = fi[n];
      end
      for (int h = 1; h < 8; h = h * 2)
         for (int g = 0; g < 8; g += 2 * h)
            for (int j = 0; j < h; j++) begin
               int t, u, k, pr, pi, at, ati;
               t   = g + j;
               u   = t + h;
               k   = j * (4 / h);
               pr  = wrap9((W_RE[k] * ar[u] - W_IM[k] * ai[u]) >>> 8);
               pi  = wrap9((W_RE[k] * ai[u] + W_IM[k] * ar[u]) >>> 8);
               at  = ar[t];
               ati = ai[t];
               ar[t] = wrap9(at + pr);
               ai[t] = wrap9(ati + pi);
               ar[u] = wrap9(at - pr);
               ai[u] = wrap9(ati - pi);
            end
      for (int n = 0; n < 8; n++) begin
         er[n] = ar[n];
         ei[n] = ai[n];
      end
   endtask

   task automatic set_frame(input int r0, input int r_step_sign, input int only_first);
      for (int n = 0; n < 8; n++) begin
         fr[n] = (only_first != 0 && n != 0) ? 0 : ((r_step_sign != 0 && n[0]) ? -r0 : r0);
         fi[n] = 0;
         er[n] = 0;
         ei[n] = 0;
      end
   endtask

   task automatic load_frame(input bit gaps);
      int acc, budget;
      acc    = 0;
      budget = 0;
      while (acc < 8 && budget < 200) begin
         bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_re    = 9'(fr[acc]);
         bus.in_im    = 9'(fi[acc]);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc++;
         @(posedge clk); #1;
         budget++;
      end
      chk("load_count", acc, 8);
   endtask

   task automatic run_frame(input bit gaps, input bit stall);
      int lat, nbusy, rdy_bad, k, stall_left, guard;
      bit seen, hold;
      @(posedge clk); #1;
      load_frame(gaps);

      // garbage presented during COMPUTE must be ignored
      bus.in_valid = 1'b1;
      bus.in_re    = 9'($urandom);
      bus.in_im    = 9'($urandom);
      lat = 0; nbusy = 0; rdy_bad = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.busy) nbusy++;
         if (bus.in_ready) rdy_bad++;
         seen = bus.out_valid;
         if (!seen) begin
            @(posedge clk); #1;
         end
      end
      chk("busy_cycles", nbusy, 12);
      chk("first_out_lat", lat, 13);
      chk("in_ready_low", rdy_bad, 0);
      bus.in_valid = 1'b0;

      k = 0; stall_left = stall ? 5 : 0; guard = 0;
      while (k < 8 && guard < 60) begin
         guard++;
         chk("out_valid", int'(bus.out_valid), 1);
         chk("in_ready_unl", int'(bus.in_ready), 0);
         chk("out_idx", int'(bus.out_idx), k);
         chk("out_re", int'($signed(bus.out_re)), er[k]);
         chk("out_im", int'($signed(bus.out_im)), ei[k]);
         hold = (k == 3 && stall_left > 0);
         bus.out_ready = !hold;
         #1;
         chk("done", int'(bus.done), (k == 7 && !hold) ? 1 : 0);
         if (hold) stall_left--;
         else k++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("unload_count", k, 8);
      chk("post_in_ready", int'(bus.in_ready), 1);
      chk("post_out_valid", int'(bus.out_valid), 0);
      chk("post_done", int'(bus.done), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_out_re"}, int'(bus.out_re), 0);
      chk({tag, "_out_im"}, int'(bus.out_im), 0);
      chk({tag, "_out_idx"}, int'(bus.out_idx), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus.out_ready = 1'b1;
      #12;
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk_reset_vals("rel");

      // all-ones
      set_frame(1, 0, 0);
      er[0] = 8;
      run_frame(1'b0, 1'b0);

      // impulse
      set_frame(100, 0, 1);
      for (int n = 0; n < 8; n++) er[n] = 100;
      run_frame(1'b0, 1'b0);

      // alternating +-16
      set_frame(16, 1, 0);
      er[4] = 128;
      run_frame(1'b0, 1'b0);

      // overflow wraps, no saturation
      set_frame(64, 0, 0);
      run_frame(1'b0, 1'b0);

      // backpressure on a directed frame, then random frames with gaps
      set_frame(1, 0, 0);
      er[0] = 8;
      run_frame(1'b1, 1'b1);
      for (int f = 0; f < 6; f++) begin
         for (int n = 0; n < 8; n++) begin
            fr[n] = int'($urandom_range(0, 511)) - 256;
            fi[n] = int'($urandom_range(0, 511)) - 256;
         end
         model();
         run_frame(1'b1, f[0]);
      end

      // reset in the 6th COMPUTE cycle abandons the frame
      set_frame(5, 0, 0);
      @(posedge clk); #1;
      load_frame(1'b0);
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_busy", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk_reset_vals("mid");
      @(posedge clk); #1;
      rst = 1'b0;
      set_frame(1, 0, 0);
      er[0] = 8;
      run_frame(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
